// File: rtl/sm_arith_pkg.sv
// -----------------------------------------------------------------------------
// sm_arith_pkg
// Shared definitions for the signed-magnitude arithmetic blocks.
//   SM_ADD_LATENCY : number of register stages in sm_add_pipe, which is also the
//                    number of cycles from an input transfer to out_valid.
//   sm_op_e        : operation select carried on the in_sub port.
// -----------------------------------------------------------------------------
package sm_arith_pkg;

   localparam int SM_ADD_LATENCY = 3;

   typedef enum logic {
      SM_OP_ADD = 1'b0,
      SM_OP_SUB = 1'b1
   } sm_op_e;

endpackage : sm_arith_pkg

// File: rtl/sm_to_tc.sv
// -----------------------------------------------------------------------------
// sm_to_tc
// Combinational conversion of a WIDTH-bit signed-magnitude value into a
// WIDTH+1-bit two's-complement value. The extra bit gives headroom, so a
// following add of two converted operands can never overflow.
// Negative zero (sign=1, magnitude=0) converts to plain 0.
//
// Ports:
//   i_sm : input  [WIDTH-1:0]  signed-magnitude operand (bit WIDTH-1 is the sign)
//   o_tc : output [WIDTH:0]    two's-complement equivalent
// -----------------------------------------------------------------------------
module sm_to_tc #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_sm,
   output logic [WIDTH:0]   o_tc
);

   logic [WIDTH:0] w_mag;

   // Zero-extend the magnitude by two bits: one for the original sign position
   // and one for the headroom bit.
   assign w_mag = {2'b00, i_sm[WIDTH-2:0]};

   // Negating a zero magnitude yields zero, so -0 maps to 0 with no special case.
   assign o_tc = i_sm[WIDTH-1] ? (-w_mag) : w_mag;

endmodule : sm_to_tc

// File: rtl/sm_add_pipe.sv
// -----------------------------------------------------------------------------
// sm_add_pipe
// Three-stage pipelined adder/subtractor for signed-magnitude operands with
// valid/ready flow control on both sides.
//   S1 : both operands converted to WIDTH+1-bit two's complement (B's sign is
//        flipped first in subtract mode).
//   S2 : WIDTH+1-bit two's-complement add.
//   S3 : conversion back to signed-magnitude plus overflow/zero flags. The S3
//        registers drive the outputs directly.
// Each stage advances when the stage after it can take its data; the resulting
// ready chain is purely combinational from out_ready back to in_ready.
//
// Build option:
//   SM_ADD_SAT_EN : when defined, an overflowing result saturates to
//                   {sign, all-ones magnitude}. When undefined the magnitude
//                   wraps to its low WIDTH-1 bits. Flags are the same either way.
//
// Ports:
//   clk       : input              rising-edge clock
//   rst_n     : input              asynchronous active-low reset
//   in_valid  : input              operand pair valid
//   in_ready  : output             block accepts an operand pair this cycle
//   in_a      : input  [WIDTH-1:0] operand A, signed-magnitude
//   in_b      : input  [WIDTH-1:0] operand B, signed-magnitude
//   in_sub    : input              0: A+B, 1: A-B
//   out_valid : output             result valid
//   out_ready : input              downstream accepts the result
//   out_sum   : output [WIDTH-1:0] result, signed-magnitude (never -0)
//   out_ovf   : output             |true result| exceeds 2^(WIDTH-1)-1
//   out_zero  : output             true result equals zero
// -----------------------------------------------------------------------------
module sm_add_pipe
   import sm_arith_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_zero
);

   // Stage valid bits: index 0 is S1, index SM_ADD_LATENCY-1 is S3.
   logic [SM_ADD_LATENCY-1:0] r_valid;

   logic [WIDTH:0]   r_a1;
   logic [WIDTH:0]   r_b1;
   logic [WIDTH:0]   r_sum2;
   logic [WIDTH-1:0] r_sum3;
   logic             r_ovf3;
   logic             r_zero3;

   logic             w_en1;
   logic             w_en2;
   logic             w_en3;

   sm_op_e           w_op;
   logic             w_bSign;
   logic [WIDTH-1:0] w_bAdj;
   logic [WIDTH:0]   w_aTc;
   logic [WIDTH:0]   w_bTc;

   logic             w_sign3;
   logic [WIDTH:0]   w_abs3;
   logic [WIDTH-2:0] w_mag3;
   logic             w_ovf3;
   logic             w_zero3;
   logic [WIDTH-1:0] w_res3;

   // A stage may load when it is empty or when its contents move on this cycle.
   assign w_en3    = !r_valid[2] || out_ready;
   assign w_en2    = !r_valid[1] || w_en3;
   assign w_en1    = !r_valid[0] || w_en2;
   assign in_ready = w_en1;

   // Subtraction is addition with B's sign flipped before conversion.
   assign w_op    = sm_op_e'(in_sub);
   assign w_bSign = in_b[WIDTH-1] ^ (w_op == SM_OP_SUB);
   assign w_bAdj  = {w_bSign, in_b[WIDTH-2:0]};

   sm_to_tc #(.WIDTH(WIDTH)) u_convA (
      .i_sm (in_a),
      .o_tc (w_aTc)
   );

   sm_to_tc #(.WIDTH(WIDTH)) u_convB (
      .i_sm (w_bAdj),
      .o_tc (w_bTc)
   );

   // Valid bits advance with their stage enables; a stage that is not enabled
   // keeps its valid, and a bubble (in_valid=0) enters as a cleared valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         if (w_en1) r_valid[0] <= in_valid;
         if (w_en2) r_valid[1] <= r_valid[0];
         if (w_en3) r_valid[2] <= r_valid[1];
      end
   end

   // S1 data: only real transfers are captured, so don't-care input data seen
   // during bubbles never enters the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a1 <= '0;
         r_b1 <= '0;
      end else if (w_en1 && in_valid) begin
         r_a1 <= w_aTc;
         r_b1 <= w_bTc;
      end
   end

   // S2 data: the extra headroom bit means this add can never overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum2 <= '0;
      end else if (w_en2 && r_valid[0]) begin
         r_sum2 <= r_a1 + r_b1;
      end
   end

   // S3 back-conversion. The absolute value is below 2^WIDTH, so any set bit at
   // or above WIDTH-1 means the magnitude does not fit in WIDTH-1 bits.
   assign w_sign3 = r_sum2[WIDTH];
   assign w_abs3  = w_sign3 ? (-r_sum2) : r_sum2;
   assign w_mag3  = w_abs3[WIDTH-2:0];
   assign w_ovf3  = |w_abs3[WIDTH:WIDTH-1];
   assign w_zero3 = (r_sum2 == '0);

   // The sign is dropped whenever the emitted magnitude is zero so that -0 is
   // never produced, including a wrapped overflow that truncates to zero.
`ifdef SM_ADD_SAT_EN
   assign w_res3 = w_ovf3 ? {w_sign3, {(WIDTH-1){1'b1}}}
                          : {w_sign3 && (w_mag3 != '0), w_mag3};
`else
   assign w_res3 = {w_sign3 && (w_mag3 != '0), w_mag3};
`endif

   // S3 data doubles as the output registers and holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum3  <= '0;
         r_ovf3  <= 1'b0;
         r_zero3 <= 1'b0;
      end else if (w_en3 && r_valid[1]) begin
         r_sum3  <= w_res3;
         r_ovf3  <= w_ovf3;
         r_zero3 <= w_zero3;
      end
   end

   assign out_valid = r_valid[2];
   assign out_sum   = r_sum3;
   assign out_ovf   = r_ovf3;
   assign out_zero  = r_zero3;

endmodule : sm_add_pipe

// File: tb/tb_sm_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_sm_add_pipe
// Directed testbench for sm_add_pipe at WIDTH=32. Each scenario task drives its
// own vectors and compares against hand-computed results. Expected overflow
// outputs follow the SM_ADD_SAT_EN build option.
// -----------------------------------------------------------------------------
module tb_sm_add_pipe;

   localparam int WIDTH = 32;

`ifdef SM_ADD_SAT_EN
   localparam logic [31:0] EXP_OVF_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] EXP_OVF_NEG = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] EXP_OVF_POS = 32'h0000_0000;
   localparam logic [31:0] EXP_OVF_NEG = 32'h8000_0001;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_ovf;
   logic        out_zero;

   int checks = 0;
   int errors = 0;

   sm_add_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   // 10 ns clock; stimulus changes and sampling happen on the falling edge.
   always #5 clk = ~clk;

   // Sends one operand pair, then captures the first result. lat counts clock
   // cycles from the cycle the pair is presented to the cycle out_valid is seen.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, output logic [31:0] sum,
                                output logic ovf, output logic zero,
                                output int lat);
      int waitCnt;
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      waitCnt   = 0;
      while (!in_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 32'hDEAD_BEEF;
      in_b     = 32'h5A5A_A5A5;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      sum  = out_sum;
      ovf  = out_ovf;
      zero = out_zero;
      @(posedge clk);
   endtask

   // Outputs while reset is held, then release.
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sub    = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00000000", out_sum); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", out_ovf); end
      checks++; if (out_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 0", out_zero); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] s; logic o, z; int lat;
      applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, s, o, z, lat);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", lat); end
      checks++; if (s !== 32'h0000_000C) begin errors++; $display("[TB] FAIL basic_sum: got %h expected 0000000c", s); end
      checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", o); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL basic_zero: got %b expected 0", z); end
      applyStimulus(32'h8000_0003, 32'h8000_0005, 1'b0, s, o, z, lat);
      checks++; if (s !== 32'h8000_0008) begin errors++; $display("[TB] FAIL negadd_sum: got %h expected 80000008", s); end
      checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL negadd_ovf: got %b expected 0", o); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL negadd_zero: got %b expected 0", z); end
   endtask

   task automatic test_mixed();
      logic [31:0] s; logic o, z; int lat;
      applyStimulus(32'h0000_0002, 32'h8000_0002, 1'b0, s, o, z, lat);
      checks++; if (s !== 32'h0000_0000) begin errors++; $display("[TB] FAIL mix_cancel_sum: got %h expected 00000000", s); end
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL mix_cancel_zero: got %b expected 1", z); end
      applyStimulus(32'h0000_0003, 32'h8000_0001, 1'b0, s, o, z, lat);
      checks++; if (s !== 32'h0000_0002) begin errors++; $display("[TB] FAIL mix_pos_sum: got %h expected 00000002", s); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL mix_pos_zero: got %b expected 0", z); end
      applyStimulus(32'h0000_0002, 32'h8000_0003, 1'b0, s, o, z, lat);
      checks++; if (s !== 32'h8000_0001) begin errors++; $display("[TB] FAIL mix_neg_sum: got %h expected 80000001", s); end
      checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL mix_neg_ovf: got %b expected 0", o); end
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, s, o, z, lat);
      checks++; if (s !== 32'h0000_0000) begin errors++; $display("[TB] FAIL negzero_sum: got %h expected 00000000", s); end
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL negzero_zero: got %b expected 1", z); end
   endtask

   task automatic test_subtract();
      logic [31:0] s; logic o, z; int lat;
      applyStimulus(32'h0000_0002, 32'h0000_0005, 1'b1, s, o, z, lat);
      checks++; if (s !== 32'h8000_0003) begin errors++; $display("[TB] FAIL sub_sum: got %h expected 80000003", s); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL sub_zero: got %b expected 0", z); end
      applyStimulus(32'h8000_0004, 32'h8000_0004, 1'b1, s, o, z, lat);
      checks++; if (s !== 32'h0000_0000) begin errors++; $display("[TB] FAIL sub_cancel_sum: got %h expected 00000000", s); end
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL sub_cancel_zero: got %b expected 1", z); end
   endtask

   task automatic test_overflow();
      logic [31:0] s; logic o, z; int lat;
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, o, z, lat);
      checks++; if (s !== EXP_OVF_POS) begin errors++; $display("[TB] FAIL ovf_pos_sum: got %h expected %h", s, EXP_OVF_POS); end
      checks++; if (o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pos_flag: got %b expected 1", o); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pos_zero: got %b expected 0", z); end
      applyStimulus(32'hFFFF_FFFF, 32'h8000_0002, 1'b0, s, o, z, lat);
      checks++; if (s !== EXP_OVF_NEG) begin errors++; $display("[TB] FAIL ovf_neg_sum: got %h expected %h", s, EXP_OVF_NEG); end
      checks++; if (o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_neg_flag: got %b expected 1", o); end
   endtask

   // Six back-to-back pairs with out_ready low during cycles 4..8 (cycle 0 is
   // the first presentation). Three results fill the pipe, so in_ready drops
   // in cycle 4; results must stay stable while stalled and emerge in order.
   task automatic test_backpressure();
      logic [31:0] vA [6];
      logic [31:0] vB [6];
      logic        vSub [6];
      logic [31:0] vExp [6];
      logic [31:0] got [6];
      int          sent = 0;
      int          recv = 0;
      logic        accepted;
      logic        prevStall = 1'b0;
      logic [31:0] prevSum = '0;
      vA   = '{32'h0000_0005, 32'h8000_0003, 32'h0000_000A, 32'h0000_0001, 32'h0000_0100, 32'h8000_0010};
      vB   = '{32'h0000_0007, 32'h8000_0005, 32'h8000_0004, 32'h0000_0002, 32'h0000_0100, 32'h0000_0001};
      vSub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vExp = '{32'h0000_000C, 32'h8000_0008, 32'h0000_0006, 32'h8000_0001, 32'h0000_0200, 32'h8000_000F};
      for (int c = 0; c < 60 && recv < 6; c++) begin
         @(negedge clk);
         out_ready = !(c >= 4 && c <= 8);
         if (sent < 6) begin
            in_valid = 1'b1;
            in_a     = vA[sent];
            in_b     = vB[sent];
            in_sub   = vSub[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prevStall) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== prevSum) begin
               errors++;
               $display("[TB] FAIL bp_stable: got valid=%b sum=%h expected valid=1 sum=%h", out_valid, out_sum, prevSum);
            end
         end
         if (c == 3) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_c3: got %b expected 1", in_ready); end
         end
         if (c == 4) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_c4: got %b expected 0", in_ready); end
         end
         accepted = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (recv < 6) got[recv] = out_sum;
            recv++;
         end
         prevStall = out_valid && !out_ready;
         prevSum   = out_sum;
         @(posedge clk);
         if (accepted) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++; if (recv !== 6) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 6", recv); end
      for (int i = 0; i < 6; i++) begin
         if (i < recv) begin
            checks++;
            if (got[i] !== vExp[i]) begin
               errors++;
               $display("[TB] FAIL bp_result%0d: got %h expected %h", i, got[i], vExp[i]);
            end
         end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
   endtask

   // Reset with three results in flight, then check a clean restart.
   task automatic test_reset_midstream();
      logic [31:0] s; logic o, z; int lat;
      logic sawValid = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sub    = 1'b0;
      in_a      = 32'h0000_0005;
      in_b      = 32'h0000_0007;
      repeat (3) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_sum: got %h expected 00000000", out_sum); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_rel_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) sawValid = 1'b1;
      end
      checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stale_valid: got %b expected 0", sawValid); end
      applyStimulus(32'h8000_0006, 32'h0000_0002, 1'b0, s, o, z, lat);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rst_new_latency: got %0d expected 3", lat); end
      checks++; if (s !== 32'h8000_0004) begin errors++; $display("[TB] FAIL rst_new_sum: got %h expected 80000004", s); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mixed();
      test_subtract();
      test_overflow();
      test_backpressure();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hang anywhere in the sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule : tb_sm_add_pipe
